sync_fifo: RTL and testbench

// - Single-clock synchronous FIFO buffer with chip-select gating.
// - Decouples a producer and a consumer that share one clock domain.
// - Reports full/empty status flags.
// - Read data is registered: it appears one clock edge after an accepted read.

---
 rtl/sync_fifo_pkg.sv | 8 +
 rtl/sync_fifo_mem.sv | 35 +++
 rtl/sync_fifo.sv | 59 +++++
 tb/tb_sync_fifo.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants for the sync_fifo block: default geometry used by the top
// and its storage sub-module.
package sync_fifo_pkg;

  localparam int DEFAULT_FIFO_DEPTH = 8;
  localparam int DEFAULT_DATA_WIDTH = 32;

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_mem.sv
// FIFO storage: DEPTH x WIDTH register array with one synchronous write port
// and one registered synchronous read port.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int WIDTH = DEFAULT_DATA_WIDTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; clearing it would turn a plain register
  // file into DEPTH*WIDTH resettable flops for no functional gain.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // NOTE: sequential state is always assigned with <= so every register
  // samples its inputs as they were just before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule : sync_fifo_mem

// File: rtl/sync_fifo.sv
// Single-clock FIFO with chip-select gating, registered read data and
// full/empty flags decoded from extended (ADDR_W+1 bit) pointers.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);

  logic [ADDR_W:0] wptr;
  logic [ADDR_W:0] rptr;
  logic            wr_ok;
  logic            rd_ok;

  // The extra MSB distinguishes a full lap from an empty FIFO.
  assign empty = (wptr == rptr);
  assign full  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                 (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);

  assign wr_ok = cs && wr_en && !full;
  assign rd_ok = cs && rd_en && !empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
    end
  end

  sync_fifo_mem #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_ok),
    .wr_addr (wptr[ADDR_W-1:0]),
    .wr_data (data_in),
    .rd_en   (rd_ok),
    .rd_addr (rptr[ADDR_W-1:0]),
    .rd_data (data_out)
  );

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (depth 8, 32-bit data).
module tb_sync_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cs = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] data_in = '0;
  logic        full;
  logic        empty;
  logic [31:0] data_out;

  int total = 0;
  int bad   = 0;

  sync_fifo #(
    .FIFO_DEPTH (8),
    .DATA_WIDTH (32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cs       (cs),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_in  (data_in),
    .full     (full),
    .empty    (empty),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, observed, expected);
    end
  endtask

  // One clock with the given request, then inputs return to idle 1ns after the edge.
  task automatic cycle(input logic c, input logic w, input logic r,
                       input logic [31:0] d);
    cs      = c;
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    @(posedge clk);
    #1;
    cs    = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic wr(input logic [31:0] d);
    cycle(1'b1, 1'b1, 1'b0, d);
  endtask

  task automatic rd();
    cycle(1'b1, 1'b0, 1'b1, 32'h0);
  endtask

  initial begin
    // Reset and idle
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_dout", data_out, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("idle_empty", 32'(empty), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 32'h55);
    check("cs0_wr_empty", 32'(empty), 32'd1);
    cycle(1'b0, 1'b1, 1'b1, 32'h66);
    check("cs0_rd_dout", data_out, 32'd0);

    // Write 1, 10, 100 then four reads
    wr(32'd1);
    check("w1_empty", 32'(empty), 32'd0);
    wr(32'd10);
    wr(32'd100);
    rd();
    check("r1_dout", data_out, 32'd1);
    rd();
    check("r2_dout", data_out, 32'd10);
    check("r2_empty", 32'(empty), 32'd0);
    rd();
    check("r3_dout", data_out, 32'd100);
    check("r3_empty", 32'(empty), 32'd1);
    rd();
    check("r4_hold", data_out, 32'd100);
    check("r4_empty", 32'(empty), 32'd1);

    // Interleaved write/read of powers of two
    for (int i = 0; i < 8; i++) begin
      wr(32'd1 << i);
      check("il_w_empty", 32'(empty), 32'd0);
      check("il_w_full", 32'(full), 32'd0);
      rd();
      check("il_r_dout", data_out, 32'd1 << i);
      check("il_r_empty", 32'(empty), 32'd1);
      check("il_r_full", 32'(full), 32'd0);
    end

    // Nine writes; the ninth is dropped
    for (int i = 0; i < 9; i++) begin
      wr(32'd1 << i);
      check("fill_full", 32'(full), (i >= 7) ? 32'd1 : 32'd0);
      check("fill_empty", 32'(empty), 32'd0);
    end
    for (int i = 0; i < 8; i++) begin
      rd();
      check("drain_dout", data_out, 32'd1 << i);
      check("drain_full", 32'(full), 32'd0);
    end
    check("drain_empty", 32'(empty), 32'd1);
    rd();
    check("drain_hold", data_out, 32'd128);

    // Wrap-around: fill, drain 3, write 3, drain all
    for (int i = 0; i < 8; i++) wr(32'hA0 + 32'(i));
    check("wrap_full", 32'(full), 32'd1);
    for (int i = 0; i < 3; i++) begin
      rd();
      check("wrap_r3", data_out, 32'hA0 + 32'(i));
    end
    check("wrap_notfull", 32'(full), 32'd0);
    for (int i = 0; i < 3; i++) wr(32'hB0 + 32'(i));
    check("wrap_refull", 32'(full), 32'd1);
    for (int i = 3; i < 8; i++) begin
      rd();
      check("wrap_ra", data_out, 32'hA0 + 32'(i));
    end
    for (int i = 0; i < 3; i++) begin
      rd();
      check("wrap_rb", data_out, 32'hB0 + 32'(i));
    end
    check("wrap_empty", 32'(empty), 32'd1);
    check("wrap_full0", 32'(full), 32'd0);

    // Concurrent read+write at mid occupancy keeps the count
    wr(32'hC0);
    wr(32'hC1);
    cycle(1'b1, 1'b1, 1'b1, 32'hC2);
    check("mid_rw_dout", data_out, 32'hC0);
    check("mid_rw_empty", 32'(empty), 32'd0);
    rd();
    check("mid_r1", data_out, 32'hC1);
    rd();
    check("mid_r2", data_out, 32'hC2);
    check("mid_empty", 32'(empty), 32'd1);

    // Concurrent read+write when full: read taken, write dropped
    for (int i = 0; i < 8; i++) wr(32'hD0 + 32'(i));
    check("cf_full", 32'(full), 32'd1);
    cycle(1'b1, 1'b1, 1'b1, 32'hEE);
    check("cf_dout", data_out, 32'hD0);
    check("cf_full_after", 32'(full), 32'd0);
    for (int i = 1; i < 8; i++) begin
      rd();
      check("cf_drain", data_out, 32'hD0 + 32'(i));
    end
    check("cf_empty", 32'(empty), 32'd1);

    // Concurrent read+write when empty: write taken, read ignored
    cycle(1'b1, 1'b1, 1'b1, 32'hF0);
    check("ce_hold", data_out, 32'hD7);
    check("ce_empty", 32'(empty), 32'd0);
    rd();
    check("ce_dout", data_out, 32'hF0);
    check("ce_empty_after", 32'(empty), 32'd1);

    // Asynchronous reset mid-stream
    wr(32'h11);
    wr(32'h22);
    #2;
    reset = 1'b0;
    #1;
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_dout", data_out, 32'd0);
    check("arst_full", 32'(full), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    rd();
    check("arst_rd_ignored", data_out, 32'd0);
    wr(32'h33);
    rd();
    check("arst_recover", data_out, 32'h33);
    check("arst_recover_empty", 32'(empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sync_fifo
